// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch queue between the PC / instruction memory
//               stage and decode. Buffers (PC, instruction) pairs in a
//               circular buffer so a decode stall does not lose fetched
//               instructions. Valid/ready on both sides, single-cycle flush
//               for branch/jump redirects.
//
// Parameters  : DEPTH   - number of entries (power of two, >= 2)
//               PC_W    - PC width
//               INSTR_W - instruction width
//
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous active-high reset
//               flush      - synchronous discard of all contents
//               in_valid   - fetch presents a pair
//               in_ready   - queue can accept a pair (registered state only)
//               in_pc      - PC of fetched instruction
//               in_instr   - fetched instruction word
//               out_valid  - head entry valid for decode
//               out_ready  - decode consumes the head
//               out_pc     - PC of head entry
//               out_instr  - instruction of head entry
//               count      - current occupancy
//
// Build option: FETCH_QUEUE_BYPASS_EN - when defined, an empty queue forwards
//               in_* straight to out_* in the same cycle (zero latency). When
//               undefined, there is no combinational path from in_* to out_*.
//
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    logic [PC_W-1:0]    r_pc_mem    [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_bypass;
    logic w_bypass_take;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == c_CNT_FULL);
    assign w_empty = (r_count == c_CNT_ZERO);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue: present the incoming pair directly. If decode takes it in
    // the same cycle it never touches storage.
    assign w_bypass      = w_empty && in_valid && !flush;
    assign w_bypass_take = w_bypass && out_ready;
`else
    assign w_bypass      = 1'b0;
    assign w_bypass_take = 1'b0;
`endif

    // in_ready is a function of registered occupancy only, so a full queue
    // never accepts a push even when the head is being popped this cycle.
    assign in_ready = !w_full;

    assign w_push = in_valid && !w_full && !flush && !w_bypass_take;
    // Pops come from storage only; a bypassed pair is not in storage.
    assign w_pop  = !w_empty && out_ready && !flush;

    assign out_valid = !w_empty || w_bypass;
    assign out_pc    = w_bypass ? in_pc    : r_pc_mem[r_rd_ptr];
    assign out_instr = w_bypass ? in_instr : r_instr_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            // Storage is cleared so the head reads as zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc_mem[r_wr_ptr]    <= in_pc;
                r_instr_mem[r_wr_ptr] <= in_instr;
                r_wr_ptr              <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue (DEPTH=4). A driver
//               issues directed cycles and pushes every pair it expects to be
//               accepted into a scoreboard queue; a monitor pops and compares
//               whenever the DUT hands a pair to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH   = 4;
    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic [2:0]         count;

    fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int m_cnt    = 0;
    logic [PC_W+INSTR_W-1:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every pair delivered to decode must be the oldest expected one.
    always @(negedge clk) begin
        if (!reset && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got pc 0x%0h expected none", out_pc);
            end else begin
                logic [PC_W+INSTR_W-1:0] e;
                e = exp_q.pop_front();
                chk("out_pc", out_pc, e[PC_W+INSTR_W-1:INSTR_W]);
                chk("out_instr", 64'(out_instr), 64'(e[INSTR_W-1:0]));
            end
        end
    end

    // One clock cycle of stimulus. Called #1 after a rising edge.
    task automatic cycle(input logic v, input logic [PC_W-1:0] pc,
                         input logic [INSTR_W-1:0] ins, input logic rdy,
                         input logic fl);
        logic push, pop, byp, byp_take, exp_ov;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = rdy;
        flush     = fl;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (m_cnt == 0) && v && !fl;
`else
        byp = 1'b0;
`endif
        byp_take = byp && rdy;
        push     = v && (m_cnt != DEPTH) && !fl && !byp_take;
        pop      = (m_cnt != 0) && rdy && !fl;
        exp_ov   = (m_cnt != 0) || byp;
        if (push || byp_take) exp_q.push_back({pc, ins});
        #1;
        chk("count", 64'(count), 64'(m_cnt));
        chk("in_ready", 64'(in_ready), 64'(m_cnt != DEPTH));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (byp) chk("bypass_pc", out_pc, pc);
        @(posedge clk);
        if (fl) begin
            m_cnt = 0;
            exp_q.delete();
        end else begin
            m_cnt = m_cnt + int'(push) - int'(pop);
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        @(posedge clk); #1;

        // Fill to full, then a rejected fifth push.
        cycle(1, 64'h0, 32'h00000013, 0, 0);
        cycle(1, 64'h4, 32'h00100093, 0, 0);
        cycle(1, 64'h8, 32'h00200113, 0, 0);
        cycle(1, 64'hC, 32'h00300193, 0, 0);
        cycle(1, 64'h10, 32'h00400213, 0, 0);
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);

        // Full with push+pop: only the pop happens.
        cycle(1, 64'h10, 32'h00400213, 1, 0);
        chk("fullpp_count", 64'(count), 64'd3);

        // Drain while pushing 0x10, 0x14; pointers wrap.
        cycle(1, 64'h10, 32'h00400213, 1, 0);
        cycle(1, 64'h14, 32'h00500293, 1, 0);
        repeat (4) cycle(0, 64'h0, 32'h0, 1, 0);
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_q_empty", 64'(exp_q.size()), 64'd0);

        // Flush with a simultaneous push of 0x100.
        cycle(1, 64'h20, 32'h11111111, 0, 0);
        cycle(1, 64'h24, 32'h22222222, 0, 0);
        cycle(1, 64'h28, 32'h33333333, 0, 0);
        cycle(1, 64'h100, 32'hDEADBEEF, 0, 1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        cycle(0, 64'h0, 32'h0, 1, 0);

        // Post-flush traffic still ordered.
        cycle(1, 64'h30, 32'h44444444, 0, 0);
        cycle(1, 64'h34, 32'h55555555, 1, 0);
        cycle(0, 64'h0, 32'h0, 1, 0);
        cycle(0, 64'h0, 32'h0, 1, 0);

        // Empty queue, push with decode ready (bypass when enabled).
        cycle(1, 64'h200, 32'h66666666, 1, 0);
        cycle(0, 64'h0, 32'h0, 1, 0);
        chk("byp_q_empty", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset between edges with two entries held.
        cycle(1, 64'h40, 32'h77777777, 0, 0);
        cycle(1, 64'h44, 32'h88888888, 0, 0);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("pre_areset_count", 64'(count), 64'd2);
        #2 reset = 1'b1;
        #1;
        chk("areset_out_valid", 64'(out_valid), 64'd0);
        chk("areset_count", 64'(count), 64'd0);
        chk("areset_out_pc", out_pc, 64'd0);
        m_cnt = 0;
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        cycle(0, 64'h0, 32'h0, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
